// File: rtl/hp_mul_seq.sv
// ---------------------------------------------------------------------------
// hp_mul_seq -- sequential IEEE-754 binary16 multiplier.
//
// A start pulse in IDLE captures both operands. The 11x11 significand product
// is then built by shift-add, one multiplier bit per cycle, over MANT_W
// cycles. A single NORM cycle resolves special values, normalises, truncates
// and packs the result. Latency is fixed at 12 cycles from the start edge.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   start    operation request, sampled only while idle
//   a, b     binary16 operands {sign, exp[4:0], frac[9:0]}
//   busy     high while an operation is in flight
//   done     one-cycle pulse when product is valid
//   product  binary16 result, held until the next done
// ---------------------------------------------------------------------------
module hp_mul_seq #(
    parameter int EXP_BIAS = 15,
    parameter int MANT_W   = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    localparam int FRAC_W = MANT_W - 1;
    localparam int ACC_W  = 2 * MANT_W;
    localparam int CNT_W  = $clog2(MANT_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [15:0]        a_q;
    logic [15:0]        b_q;
    logic [MANT_W-1:0]  mcand;
    logic [MANT_W-1:0]  mplier;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic [15:0]        pack;

    // The hidden bit is always set; zero/subnormal operands are caught as
    // special cases in NORM, so their shift-add result is simply discarded.
    assign mcand = {1'b1, a_q[FRAC_W-1:0]};

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: the default assignment at the top of each combinational block
    // guarantees every path drives the output, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = MUL;
            // cnt moves from MANT_W-1 to MANT_W on this edge: last iteration.
            MUL:     if (cnt == CNT_W'(MANT_W - 1)) state_next = NORM;
            NORM:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic: busy decode and the normalise/pack datapath
    // -----------------------------------------------------------------------
    logic              sgn;
    logic [4:0]        ea;
    logic [4:0]        eb;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic signed [6:0] e_fin;
    logic [FRAC_W-1:0] frac;

    always_comb begin
        busy   = (state != IDLE);

        sgn    = a_q[15] ^ b_q[15];
        ea     = a_q[14:10];
        eb     = b_q[14:10];
        a_nan  = (ea == 5'h1F) && (a_q[FRAC_W-1:0] != '0);
        b_nan  = (eb == 5'h1F) && (b_q[FRAC_W-1:0] != '0);
        a_inf  = (ea == 5'h1F) && (a_q[FRAC_W-1:0] == '0);
        b_inf  = (eb == 5'h1F) && (b_q[FRAC_W-1:0] == '0);
        a_zero = (ea == 5'h00);
        b_zero = (eb == 5'h00);

        // Signed 7-bit exponent covers -15..48 including the normalise bump.
        e_fin = 7'({2'b00, ea}) + 7'({2'b00, eb}) - 7'(EXP_BIAS);
        frac  = acc[ACC_W-3 -: FRAC_W];
        if (acc[ACC_W-1]) begin
            // Significand product in [2,4): drop one more LSB, bump exponent.
            frac  = acc[ACC_W-2 -: FRAC_W];
            e_fin = e_fin + 7'sd1;
        end

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            pack = 16'h7E00;
        end else if (a_inf || b_inf) begin
            pack = {sgn, 5'h1F, 10'h000};
        end else if (a_zero || b_zero) begin
            pack = {sgn, 15'h0000};
        end else if (e_fin >= 7'sd31) begin
            pack = {sgn, 5'h1F, 10'h000};
        end else if (e_fin <= 7'sd0) begin
            pack = {sgn, 15'h0000};
        end else begin
            pack = {sgn, e_fin[4:0], frac};
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        mplier <= {1'b1, b[FRAC_W-1:0]};
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + (ACC_W'(mcand) << cnt);
                    end
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                NORM: begin
                    product <= pack;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hp_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_hp_mul_seq -- directed bench for hp_mul_seq.
//
// Covers reset state, fixed latency, normal products, special values,
// start-while-busy, back-to-back operation, mid-operation reset, and a sweep
// of normal operands against a truncating binary16 reference function.
// ---------------------------------------------------------------------------
module tb_hp_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int n_vec = 0;
    int n_bad = 0;

    hp_mul_seq #(
        .EXP_BIAS(15),
        .MANT_W  (11)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .product(product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        assert (got === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    // Start an operation; returns 1 time unit after the accepting edge (T0).
    task automatic launch(input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Advance at least one edge, then until done is seen (bounded).
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 40);
    endtask

    task automatic do_op(input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] expv, input string tag);
        int cyc;
        launch(x, y);
        check({tag, " busy"}, 32'(busy), 32'd1);
        wait_done(cyc);
        check({tag, " latency"}, cyc, 32'd12);
        check(tag, 32'(product), 32'(expv));
    endtask

    // Truncating binary16 reference product.
    function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        logic s;
        int   ex, ey, fx, fy, e, m;
        logic xnan, ynan, xinf, yinf, xz, yz;
        s    = x[15] ^ y[15];
        ex   = int'(x[14:10]);
        ey   = int'(y[14:10]);
        fx   = int'(x[9:0]);
        fy   = int'(y[9:0]);
        xnan = (ex == 31) && (fx != 0);
        ynan = (ey == 31) && (fy != 0);
        xinf = (ex == 31) && (fx == 0);
        yinf = (ey == 31) && (fy == 0);
        xz   = (ex == 0);
        yz   = (ey == 0);
        if (xnan || ynan || (xinf && yz) || (yinf && xz)) return 16'h7E00;
        if (xinf || yinf) return {s, 15'h7C00};
        if (xz || yz) return {s, 15'h0000};
        m = (1024 + fx) * (1024 + fy);
        e = ex + ey - 15;
        if (m >= (1 << 21)) begin
            m = m / 2;
            e = e + 1;
        end
        if (e >= 31) return {s, 15'h7C00};
        if (e <= 0) return {s, 15'h0000};
        return {s, 5'(e), 10'((m / 1024) % 1024)};
    endfunction

    initial begin
        int          cyc;
        int          seen;
        logic [15:0] x;
        logic [15:0] y;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset product", 32'(product), 32'h0);
        rst = 1'b0;

        // Basic product with full latency and single-cycle done.
        do_op(16'h4000, 16'h4200, 16'h4600, "2x3");
        @(posedge clk);
        #1;
        check("done width", 32'(done), 32'd0);
        check("product hold", 32'(product), 32'h4600);

        do_op(16'h3E00, 16'h3E00, 16'h4080, "1.5x1.5");
        do_op(16'hC000, 16'h3800, 16'hBC00, "-2x0.5");

        // Special values.
        do_op(16'h7800, 16'h7800, 16'h7C00, "overflow");
        do_op(16'h0400, 16'h0400, 16'h0000, "underflow");
        do_op(16'h8000, 16'h4200, 16'h8000, "signed zero");
        do_op(16'h7C00, 16'h0000, 16'h7E00, "inf x zero");
        do_op(16'h7C00, 16'hC000, 16'hFC00, "signed inf");
        do_op(16'h7E01, 16'h3C00, 16'h7E00, "nan in");

        // start at T5 with other operands is ignored; inputs change freely.
        launch(16'h4000, 16'h4200);
        repeat (4) @(posedge clk);
        @(negedge clk);
        a     = 16'h3C00;
        b     = 16'h3C00;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(cyc);
        check("ignore latency", cyc, 32'd7);
        check("ignore product", 32'(product), 32'h4600);
        @(posedge clk);
        #1;
        check("ignore no extra busy", 32'(busy), 32'd0);

        // Continuous start: a new operation is accepted on each done cycle.
        @(negedge clk);
        a     = 16'h3E00;
        b     = 16'h3E00;
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(cyc);
        check("b2b first latency", cyc, 32'd12);
        check("b2b first", 32'(product), 32'h4080);
        a = 16'h4000;
        b = 16'h4200;
        wait_done(cyc);
        check("b2b period 1", cyc, 32'd13);
        check("b2b second", 32'(product), 32'h4600);
        a = 16'hC000;
        b = 16'h3800;
        wait_done(cyc);
        start = 1'b0;
        check("b2b period 2", cyc, 32'd13);
        check("b2b third", 32'(product), 32'hBC00);
        repeat (14) @(posedge clk);
        #1;
        check("b2b drained", 32'(busy), 32'd0);

        // Reset at T6 aborts the operation with no done pulse.
        launch(16'h4000, 16'h4200);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort product", 32'(product), 32'h0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("abort no done", seen, 32'd0);
        do_op(16'h3E00, 16'h3E00, 16'h4080, "after abort");

        // Sweep of normal operands against the reference function.
        for (int i = 0; i < 1000; i++) begin
            x = {1'($urandom_range(1)), 5'($urandom_range(30, 1)), 10'($urandom_range(1023))};
            y = {1'($urandom_range(1)), 5'($urandom_range(30, 1)), 10'($urandom_range(1023))};
            do_op(x, y, ref_mul(x, y), "sweep");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
